// File: rtl/uart_sim_pkg.sv
// rtl/uart_sim_pkg.sv - shared definitions for the simulated UART-lite AXI slaves
// Purpose: register offsets, AXI response codes, STAT bit positions and the
//          read-side FSM state type, shared by the read and write slaves.
// Ports:   none (package).
package uart_sim_pkg;

  localparam logic [3:0] REG_RX_FIFO = 4'h0;
  localparam logic [3:0] REG_TX_FIFO = 4'h4;
  localparam logic [3:0] REG_STAT    = 4'h8;
  localparam logic [3:0] REG_CTRL    = 4'hC;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;
  localparam int STAT_OVERRUN  = 5;

  typedef enum logic [0:0] {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

endpackage

// File: rtl/uart_sim_rx_fifo.sv
// rtl/uart_sim_rx_fifo.sv - synchronous byte FIFO with flush for the UART RX path
// Purpose: DEPTH-entry 8-bit FIFO, first-word-fall-through head output.
// Ports:   i_clk/i_rst    clock, synchronous active-high reset
//          i_clr          flush (overrides push/pop)
//          i_push/i_data  write request and byte (ignored when full)
//          i_pop          read request (ignored when empty)
//          o_head         byte at the head of the queue
//          o_full/o_empty/o_level  occupancy flags and count 0..DEPTH
module uart_sim_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  input  logic        i_pop,
  output logic [7:0]  o_head,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_level
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic          do_push, do_pop;

  assign o_full  = (lvl_q == LVL_FULL);
  assign o_empty = (lvl_q == '0);
  assign o_head  = mem_q[rd_q];
  assign o_level = lvl_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    do_push = i_push && !o_full;
    do_pop  = i_pop && !o_empty;
    if (i_clr) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = i_data;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   lvl_d = lvl_q + (AW+1)'(1);
        2'b01:   lvl_d = lvl_q - (AW+1)'(1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
    // Storage needs no reset: the level/pointers define what is valid.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axilite_s_r_uart.sv
// rtl/axilite_s_r_uart.sv - AXI4-Lite read slave for the simulated UART-lite
// Purpose: buffers upstream RX bytes, serves RX_FIFO/STAT_REG reads and
//          exports live status to the write-side slave.
// Ports:   i_clk/i_rst              clock, synchronous active-high reset
//          i_s_ar*/o_s_ar*          AXI read-address channel
//          o_s_r*/i_s_rready        AXI read-data channel (registered)
//          i_rx_data/valid, o_rx_ready  upstream byte stream
//          i_rx_clr, i_intr_en      flush pulse and interrupt enable from write slave
//          o_stat, o_rx_level       live status word and FIFO occupancy
module axilite_s_r_uart
  import uart_sim_pkg::*;
#(
  parameter int ADRW  = 32,
  parameter int DATW  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [ADRW-1:0]          i_s_araddr,
  input  logic                     i_s_arvalid,
  output logic                     o_s_arready,
  output logic [DATW-1:0]          o_s_rdata,
  output logic [1:0]               o_s_rresp,
  output logic                     o_s_rvalid,
  input  logic                     i_s_rready,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  output logic                     o_rx_ready,
  input  logic                     i_rx_clr,
  input  logic                     i_intr_en,
  output logic [DATW-1:0]          o_stat,
  output logic [$clog2(DEPTH):0]   o_rx_level
);

  rd_state_e       state_q, state_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [DATW-1:0] rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            overrun_q, overrun_d;

  logic       fifo_pop, fifo_full, fifo_empty, stat_rd, ovr_evt;
  logic [7:0] fifo_head;
  logic       unused_addr;

  assign unused_addr = ^i_s_araddr[ADRW-1:4];

  uart_sim_rx_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_rx_clr),
    .i_push  (i_rx_valid),
    .i_data  (i_rx_data),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_rx_level)
  );

  assign o_rx_ready = !fifo_full;
  // A byte offered while full is dropped; that is the overrun event.
  assign ovr_evt    = i_rx_valid && fifo_full;

  always_comb begin
    o_stat                = '0;
    o_stat[STAT_RX_VALID] = !fifo_empty;
    o_stat[STAT_RX_FULL]  = fifo_full;
    o_stat[STAT_TX_EMPTY] = 1'b1;
    o_stat[STAT_TX_FULL]  = 1'b0;
    o_stat[STAT_INTR_EN]  = i_intr_en;
    o_stat[STAT_OVERRUN]  = overrun_q;
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    fifo_pop  = 1'b0;
    stat_rd   = 1'b0;
    case (state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (i_s_arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          state_d   = RD_RESP;
          rdata_d   = '0;
          rresp_d   = AXI_RESP_OKAY;
          case (i_s_araddr[3:0])
            REG_RX_FIFO: begin
              if (!fifo_empty) begin
                rdata_d[7:0] = fifo_head;
                fifo_pop     = 1'b1;
              end
            end
            REG_STAT: begin
              rdata_d = o_stat;
              stat_rd = 1'b1;
            end
            REG_TX_FIFO, REG_CTRL: rdata_d = '0;
            default: rresp_d = AXI_RESP_SLVERR;
          endcase
        end
      end
      RD_RESP: begin
        if (i_s_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Flush beats everything; otherwise a same-cycle overrun survives a STAT read.
  always_comb begin
    overrun_d = overrun_q;
    if (stat_rd) overrun_d = 1'b0;
    if (ovr_evt) overrun_d = 1'b1;
    if (i_rx_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= RD_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_s_arready = arready_q;
  assign o_s_rvalid  = rvalid_q;
  assign o_s_rdata   = rdata_q;
  assign o_s_rresp   = rresp_q;

endmodule

// File: tb/tb_axilite_s_r_uart.sv
// tb/tb_axilite_s_r_uart.sv - scoreboard bench for the UART-lite AXI read slave
module tb_axilite_s_r_uart;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready, rx_clr, intr_en;
  logic [31:0] stat;
  logic [4:0]  rx_level;

  always #5 clk = ~clk;

  axilite_s_r_uart dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_s_araddr  (araddr),
    .i_s_arvalid (arvalid),
    .o_s_arready (arready),
    .o_s_rdata   (rdata),
    .o_s_rresp   (rresp),
    .o_s_rvalid  (rvalid),
    .i_s_rready  (rready),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rx_ready),
    .i_rx_clr    (rx_clr),
    .i_intr_en   (intr_en),
    .o_stat      (stat),
    .o_rx_level  (rx_level)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_fifo[$];
  logic       m_ovr;
  int         n_vec  = 0;
  int         n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_stat();
    logic [31:0] s;
    s    = 32'h0000_0004;
    s[0] = (m_fifo.size() != 0);
    s[1] = (m_fifo.size() == DEPTH);
    s[4] = intr_en;
    s[5] = m_ovr;
    return s;
  endfunction

  task automatic m_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b00;
    case (a)
      4'h0: if (m_fifo.size() != 0) d = {24'h0, m_fifo.pop_front()};
      4'h4, 4'hC: d = '0;
      4'h8: begin
        d     = m_stat();
        m_ovr = 1'b0;
      end
      default: r = 2'b10;
    endcase
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    check("rx_ready", rx_ready, m_fifo.size() != DEPTH);
    rx_data  = b;
    rx_valid = 1'b1;
    if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
    else m_ovr = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("level", rx_level, m_fifo.size());
  endtask

  task automatic axi_rd(input logic [3:0] a, input int hold, input bit with_clr);
    exp_t e;
    int   t;
    @(posedge clk); #1;
    araddr  = {28'h0, a};
    arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) begin
      check("ar_timeout", 32'd0, 32'd1);
      arvalid = 1'b0;
      return;
    end
    check("rvalid_pre", rvalid, 1'b0);
    m_read(a, e.data, e.resp);
    if (with_clr) begin
      rx_clr = 1'b1;
      m_fifo.delete();
      m_ovr = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rx_clr  = 1'b0;
    check("rvalid_lat", rvalid, 1'b1);
    check("arready_busy", arready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_rvalid", rvalid, 1'b1);
      check("hold_rdata", rdata, e.data);
      check("hold_level", rx_level, m_fifo.size());
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_done", rvalid, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rvalid === 1'b1 && rready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", rresp, e.resp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    rx_data = '0; rx_valid = 1'b0; rx_clr = 1'b0; intr_en = 1'b0; m_ovr = 1'b0;

    // reset state
    @(posedge clk); #1;
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rresp", rresp, 2'b00);
    check("rst_level", rx_level, 5'd0);
    check("rst_stat", stat, 32'h04);
    rst = 1'b0;
    @(posedge clk); #1;
    check("arready_up", arready, 1'b1);

    // STAT after reset
    axi_rd(4'h8, 0, 1'b0);

    // two bytes in order, then empty read
    push(8'h41);
    push(8'h42);
    axi_rd(4'h0, 0, 1'b0);
    axi_rd(4'h0, 0, 1'b0);
    axi_rd(4'h0, 0, 1'b0);
    check("stat_rx_valid", stat[0], 1'b0);
    axi_rd(4'h8, 0, 1'b0);

    // fill, overflow, overrun sticky then cleared by STAT read
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    check("full_rx_ready", rx_ready, 1'b0);
    push(8'hEE);
    check("stat_overrun", stat, 32'h27);
    axi_rd(4'h8, 0, 1'b0);
    axi_rd(4'h8, 0, 1'b0);
    check("stat_after_clr", stat, m_stat());

    // back-pressure on R: data stable, single pop
    axi_rd(4'h0, 5, 1'b0);
    check("one_pop_level", rx_level, 5'd15);

    // flush alone, then flush concurrent with an RX read
    @(posedge clk); #1;
    rx_clr = 1'b1;
    m_fifo.delete();
    m_ovr = 1'b0;
    @(posedge clk); #1;
    rx_clr = 1'b0;
    check("clr_level", rx_level, 5'd0);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    axi_rd(4'h0, 0, 1'b1);
    check("clr_rd_level", rx_level, 5'd0);

    // decode errors, other registers, intr_en in STAT
    axi_rd(4'h2, 0, 1'b0);
    axi_rd(4'h4, 0, 1'b0);
    axi_rd(4'hC, 0, 1'b0);
    intr_en = 1'b1;
    axi_rd(4'h8, 0, 1'b0);
    check("stat_intr", stat, 32'h14);

    // random mix against the model
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 4))
        0, 1: push(8'($urandom_range(0, 255)));
        2: axi_rd(4'h0, $urandom_range(0, 2), 1'b0);
        3: axi_rd(($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, 0, 1'b0);
        default: begin
          intr_en = 1'($urandom_range(0, 1));
          axi_rd(4'($urandom_range(0, 15)), 0, 1'b0);
        end
      endcase
    end
    check("final_stat", stat, m_stat());

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
